// File: rtl/sbus_master_port.sv
// Initiator end of the point-to-point serial bus. Accepts one host request at a
// time, frames it onto the tx lane of the addressed slave (start, ack, 12 address
// bits, mode bit, 8 data bits), collects read data from rx and reports completion.
module sbus_master_port #(
  parameter int NUM_SLAVES  = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int IDLE_GAP    = 2,
  parameter int RESET_QUIET = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [13:0]           req_addr,
  input  logic                  req_write,
  input  logic [7:0]            req_wdata,
  output logic                  resp_valid,
  output logic [7:0]            resp_rdata,
  output logic                  resp_err,
  output logic [NUM_SLAVES-1:0] tx,
  input  logic [NUM_SLAVES-1:0] rx
);

  localparam int CNT_W      = 16;
  localparam int GAP_LAST   = (IDLE_GAP > 1) ? IDLE_GAP - 1 : 1;
  localparam int QUIET_LAST = (RESET_QUIET > 1) ? RESET_QUIET - 1 : 0;

  // Bit positions within the frame, counted in edges after the ack edge
  localparam logic [CNT_W-1:0] POS_ADDR  = CNT_W'(3);
  localparam logic [CNT_W-1:0] POS_MODE  = CNT_W'(15);
  localparam logic [CNT_W-1:0] POS_DEND  = CNT_W'(24);
  localparam logic [CNT_W-1:0] POS_RSAMP = CNT_W'(18);
  localparam logic [CNT_W-1:0] POS_LAST  = CNT_W'(25);

  typedef enum logic [2:0] {
    S_QUIET,
    S_IDLE,
    S_BAD,
    S_WAIT_ACK,
    S_FRAME,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   tx_q, tx_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [7:0]              resp_rdata_q, resp_rdata_d;

  logic [11:0]             addr_q, addr_d;
  logic                    write_q, write_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [1:0]              lane_q, lane_d;
  logic [7:0]              rbuf_q, rbuf_d;

  logic                    rx_lane;
  logic                    drive_en;
  logic                    drive_bit;
  logic [1:0]              drive_lane;

  // Select the rx line of the active lane (idle-high when the lane does not exist)
  always_comb begin
    rx_lane = 1'b1;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (lane_q == 2'(k)) rx_lane = rx[k];
    end
  end

  // Next-state, frame bit generation and response logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    lane_d       = lane_q;
    rbuf_d       = rbuf_q;
    drive_en     = 1'b0;
    drive_bit    = 1'b1;
    drive_lane   = lane_q;

    case (state_q)
      S_QUIET: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNT_W'(QUIET_LAST)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr[11:0];
          write_d = req_write;
          wdata_d = req_wdata;
          lane_d  = req_addr[13:12];
          if (int'(req_addr[13:12]) >= NUM_SLAVES) begin
            state_d = S_BAD;
          end else begin
            // Start bit goes out on the accept edge itself
            state_d    = S_WAIT_ACK;
            cnt_d      = CNT_W'(1);
            drive_en   = 1'b1;
            drive_bit  = 1'b0;
            drive_lane = req_addr[13:12];
          end
        end
      end

      S_BAD: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = S_IDLE;
      end

      S_WAIT_ACK: begin
        if (!rx_lane) begin
          state_d   = S_FRAME;
          cnt_d     = CNT_W'(1);
          drive_en  = 1'b1;
          drive_bit = 1'b0;
        end else if (cnt_q >= CNT_W'(ACK_TIMEOUT)) begin
          state_d      = S_GAP;
          cnt_d        = CNT_W'(1);
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          drive_en  = 1'b1;
          drive_bit = 1'b0;
        end
      end

      S_FRAME: begin
        // cnt_q is the edge offset from the ack edge; address and data shift out LSB first
        cnt_d    = cnt_q + 1'b1;
        drive_en = 1'b1;
        if (cnt_q < POS_ADDR) begin
          drive_bit = 1'b0;
        end else if (cnt_q < POS_MODE) begin
          drive_bit = addr_q[0];
          addr_d    = addr_q >> 1;
        end else if (cnt_q == POS_MODE) begin
          drive_bit = write_q;
        end else if (write_q && (cnt_q < POS_DEND)) begin
          drive_bit = wdata_q[0];
          wdata_d   = wdata_q >> 1;
        end else begin
          drive_bit = 1'b1;
        end
        if (!write_q && (cnt_q >= POS_RSAMP)) rbuf_d = {rx_lane, rbuf_q[7:1]};
        if (cnt_q == POS_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end

      S_RELEASE: begin
        if (rx_lane) begin
          state_d      = S_GAP;
          cnt_d        = CNT_W'(1);
          resp_valid_d = 1'b1;
          if (!write_q) resp_rdata_d = rbuf_q;
        end else if (cnt_q >= CNT_W'(ACK_TIMEOUT)) begin
          state_d      = S_GAP;
          cnt_d        = CNT_W'(1);
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q >= CNT_W'(GAP_LAST)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Build the registered tx word: only the driven lane may leave the idle-high level
  always_comb begin
    tx_d = '1;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (drive_en && (drive_lane == 2'(k))) tx_d[k] = drive_bit;
    end
    req_ready_d = (state_d == S_IDLE);
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_QUIET;
      cnt_q        <= '0;
      tx_q         <= '1;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Latched request and read shift register; meaningful only while a frame is active
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
    lane_q  <= lane_d;
    rbuf_q  <= rbuf_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_sbus_master_port.sv
// Directed bench for sbus_master_port with a cycle-stepped slave model on rx.
module tb_sbus_master_port;

  localparam int NS  = 2;
  localparam int TO  = 16;
  localparam int GAP = 2;
  localparam int RQ  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [13:0]   req_addr;
  logic          req_write;
  logic [7:0]    req_wdata;
  logic          resp_valid;
  logic [7:0]    resp_rdata;
  logic          resp_err;
  logic [NS-1:0] tx;
  logic [NS-1:0] rx;

  sbus_master_port #(
    .NUM_SLAVES (NS),
    .ACK_TIMEOUT(TO),
    .IDLE_GAP   (GAP),
    .RESET_QUIET(RQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .tx        (tx),
    .rx        (rx)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int checks   = 0;
  int failures = 0;

  // Results of the last run_txn call
  logic [NS-1:0] txh [0:99];
  int            other_bad;
  int            s_edge;
  int            resp_k;
  logic          resp_e;
  logic [7:0]    resp_d;

  // Issue one request and play a conforming (or silent) slave on its lane.
  // Slave: ack at s+3, data bits at a+18.., release at a+26. Stops after resp_valid.
  task automatic run_txn(input logic [13:0] addr, input logic wr, input logic [7:0] wd,
                         input logic ack_on, input logic [7:0] sd, input logic keep_valid);
    int   n;
    int   lane;
    int   p;
    logic b;
    lane      = int'(addr[13:12]);
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
    s_edge    = edge_no;
    resp_k    = -1;
    resp_e    = 1'b0;
    resp_d    = 8'h00;
    other_bad = 0;
    for (int i = 0; i < 100; i++) txh[i] = '1;
    txh[0] = tx;
    for (int j = 0; j < NS; j++) if (j != lane && tx[j] !== 1'b1) other_bad++;
    for (int k = 1; k < 100 && resp_k < 0; k++) begin
      p = k - 3;
      if (!ack_on || k < 3 || p >= 26) b = 1'b1;
      else if (!wr && p >= 18 && p <= 25) b = sd[p-18];
      else b = 1'b0;
      for (int j = 0; j < NS; j++) rx[j] = (j == lane) ? b : 1'b1;
      @(posedge clk); #1;
      txh[k] = tx;
      for (int j = 0; j < NS; j++) if (j != lane && tx[j] !== 1'b1) other_bad++;
      if (resp_valid === 1'b1) begin
        resp_k = k;
        resp_e = resp_err;
        resp_d = resp_rdata;
      end
    end
    rx = '1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; rx = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx !== 2'b11) begin failures++; $display("FAIL reset_tx got=%b exp=11", tx); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", resp_rdata); end
    rst = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != RQ) begin failures++; $display("FAIL reset_quiet got=%0d exp=%0d", n, RQ); end
  endtask

  task automatic test_write();
    logic [20:0] got;
    logic [5:0]  pre;
    run_txn(14'h12A5, 1'b1, 8'h3C, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) pre[i] = txh[i][1];
    for (int i = 0; i < 21; i++) got[i] = txh[6+i][1];
    checks++; if (pre !== 6'b000000) begin failures++; $display("FAIL wr_start got=%b exp=000000", pre); end
    // addr 0x2A5 LSB first, mode 1, data 0x3C LSB first
    checks++; if (got !== 21'h792A5) begin failures++; $display("FAIL wr_stream got=%h exp=792a5", got); end
    checks++; if (txh[27][1] !== 1'b1) begin failures++; $display("FAIL wr_stop got=%b exp=1", txh[27][1]); end
    checks++; if (resp_k != 29) begin failures++; $display("FAIL wr_latency got=%0d exp=29", resp_k); end
    checks++; if (resp_e !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", resp_e); end
    checks++; if (resp_d !== 8'h00) begin failures++; $display("FAIL wr_rdata got=%h exp=00", resp_d); end
    checks++; if (other_bad != 0) begin failures++; $display("FAIL wr_other got=%0d exp=0", other_bad); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL wr_pulse got=%b exp=0", resp_valid); end
  endtask

  task automatic test_read();
    logic [20:0] got;
    run_txn(14'h1000, 1'b0, 8'h00, 1'b1, 8'h1A, 1'b0);
    for (int i = 0; i < 21; i++) got[i] = txh[6+i][1];
    // addr 0, mode 0, lane released high during the data phase
    checks++; if (got !== 21'h1FE000) begin failures++; $display("FAIL rd_stream got=%h exp=1fe000", got); end
    checks++; if (resp_k != 29) begin failures++; $display("FAIL rd_latency got=%0d exp=29", resp_k); end
    checks++; if (resp_e !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", resp_e); end
    checks++; if (resp_d !== 8'h1A) begin failures++; $display("FAIL rd_data got=%h exp=1a", resp_d); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 8'h1A) begin failures++; $display("FAIL rd_hold got=%b/%h exp=0/1a", resp_valid, resp_rdata); end
  endtask

  task automatic test_bad_lane();
    run_txn(14'h3000, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
    checks++; if (txh[0] !== 2'b11) begin failures++; $display("FAIL bad_tx0 got=%b exp=11", txh[0]); end
    checks++; if (resp_k != 1) begin failures++; $display("FAIL bad_latency got=%0d exp=1", resp_k); end
    checks++; if (resp_e !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", resp_e); end
    checks++; if (other_bad != 0) begin failures++; $display("FAIL bad_toggle got=%0d exp=0", other_bad); end
    checks++; if (resp_d !== 8'h1A) begin failures++; $display("FAIL bad_rdata got=%h exp=1a", resp_d); end
  endtask

  task automatic test_silent();
    int d1;
    run_txn(14'h1123, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    checks++; if (txh[15][1] !== 1'b0 || txh[16][1] !== 1'b1) begin failures++; $display("FAIL sil_tx got=%b%b exp=01", txh[15][1], txh[16][1]); end
    checks++; if (resp_k != TO) begin failures++; $display("FAIL sil_latency got=%0d exp=%0d", resp_k, TO); end
    checks++; if (resp_e !== 1'b1) begin failures++; $display("FAIL sil_err got=%b exp=1", resp_e); end
    checks++; if (other_bad != 0) begin failures++; $display("FAIL sil_other got=%0d exp=0", other_bad); end
    d1 = s_edge + resp_k;
    run_txn(14'h0456, 1'b1, 8'h81, 1'b1, 8'h00, 1'b0);
    checks++; if (s_edge - d1 != GAP) begin failures++; $display("FAIL sil_gap got=%0d exp=%0d", s_edge - d1, GAP); end
    checks++; if (resp_k != 29 || resp_e !== 1'b0) begin failures++; $display("FAIL sil_next got=%0d/%b exp=29/0", resp_k, resp_e); end
  endtask

  task automatic test_back_to_back();
    int          d1;
    logic [20:0] got;
    run_txn(14'h1F0F, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b1);
    checks++; if (resp_k != 29 || resp_e !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=29/0", resp_k, resp_e); end
    checks++; if (other_bad != 0) begin failures++; $display("FAIL b2b_other1 got=%0d exp=0", other_bad); end
    d1 = s_edge + resp_k;
    run_txn(14'h0ABC, 1'b0, 8'h00, 1'b1, 8'h6D, 1'b0);
    for (int i = 0; i < 21; i++) got[i] = txh[6+i][0];
    checks++; if (s_edge - d1 != GAP) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", s_edge - d1, GAP); end
    checks++; if (got !== 21'h1FEABC) begin failures++; $display("FAIL b2b_stream got=%h exp=1feabc", got); end
    checks++; if (resp_d !== 8'h6D || resp_e !== 1'b0) begin failures++; $display("FAIL b2b_data got=%h/%b exp=6d/0", resp_d, resp_e); end
    checks++; if (other_bad != 0) begin failures++; $display("FAIL b2b_other2 got=%0d exp=0", other_bad); end
  endtask

  task automatic test_reset_midframe();
    int n;
    int quiet_bad;
    req_addr = 14'h1200; req_write = 1'b1; req_wdata = 8'hF0; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      rx = (k < 3) ? 2'b11 : 2'b01;
      @(posedge clk); #1;
    end
    // edge a+8 carries addr bit 5 of 0x200, which is 0
    checks++; if (tx !== 2'b01) begin failures++; $display("FAIL rmf_before got=%b exp=01", tx); end
    #1 rst = 1'b1;
    #1;
    checks++; if (tx !== 2'b11) begin failures++; $display("FAIL rmf_tx got=%b exp=11", tx); end
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 8'h00) begin failures++; $display("FAIL rmf_ctrl got=%b%b/%h exp=00/00", req_ready, resp_valid, resp_rdata); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    quiet_bad = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      rx = (n < 10) ? 2'b01 : 2'b11;
      @(posedge clk); #1;
      if (tx !== 2'b11) quiet_bad++;
      n++;
    end
    rx = '1;
    checks++; if (n != RQ) begin failures++; $display("FAIL rmf_quiet got=%0d exp=%0d", n, RQ); end
    checks++; if (quiet_bad != 0) begin failures++; $display("FAIL rmf_quiet_tx got=%0d exp=0", quiet_bad); end
    run_txn(14'h1055, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
    checks++; if (resp_k != 29 || resp_e !== 1'b0) begin failures++; $display("FAIL rmf_read got=%0d/%b exp=29/0", resp_k, resp_e); end
    checks++; if (resp_d !== 8'hC3) begin failures++; $display("FAIL rmf_rdata got=%h exp=c3", resp_d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_lane();
    test_silent();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
